// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and shared-memory port around mem_port_arbiter.
// slave is the arbiter's view; master is the view of the pipeline plus memory model.
interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          if_stall;
  logic          d_stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, if_stall, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, if_stall, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data ports.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data wins every tie.
module mem_port_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          owner_data_q, owner_data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_data;
  logic          if_ready, d_ready;

`ifdef MEM_ARB_RR_EN
  logic last_data_q, last_data_d;
  // On a tie the port that was not granted last goes first.
  assign grant_data = bus.d_req & (~bus.if_req | ~last_data_q);
`else
  assign grant_data = bus.d_req;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_data_d = owner_data_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_data_d  = last_data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.if_req | bus.d_req) begin
          owner_data_d = grant_data;
          addr_d       = grant_data ? bus.d_addr : bus.if_addr;
          we_d         = grant_data & bus.d_we;
          wdata_d      = grant_data ? bus.d_wdata : wdata_q;
`ifdef MEM_ARB_RR_EN
          last_data_d  = grant_data;
`endif
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // mem_rdata is valid exactly LAT cycles after the strobe; writes leave rdata alone.
          if (!owner_data_q)
            if_rdata_d = bus.mem_rdata;
          else if (!we_q)
            d_rdata_d = bus.mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      owner_data_q <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
`ifdef MEM_ARB_RR_EN
      last_data_q  <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_data_q <= owner_data_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_data_q  <= last_data_d;
`endif
    end
  end

  assign if_ready      = (state_q == ST_RESP) & ~owner_data_q;
  assign d_ready       = (state_q == ST_RESP) & owner_data_q;
  assign bus.if_ready  = if_ready;
  assign bus.d_ready   = d_ready;
  assign bus.if_stall  = bus.if_req & ~if_ready;
  assign bus.d_stall   = bus.d_req & ~d_ready;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = (state_q == ST_ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule
